// File: rtl/naive_bus_arb_pkg.sv
// Shared types for the two-master naive bus arbiter.
package naive_bus_arb_pkg;
  localparam int NUM_MST = 2;
  typedef enum logic {M_CORE = 1'b0, M_DBG = 1'b1} arb_mst_t;
endpackage

// File: rtl/naive_bus.sv
// Naive bus: independent read and write request/grant channels, read data one cycle after grant.
interface naive_bus #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic              rd_gnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W/8-1:0] rd_be;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic              wr_gnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W/8-1:0] wr_be;
  logic [DATA_W-1:0] wr_wdata;

  modport master (
    output rd_req, rd_addr, rd_be, wr_req, wr_addr, wr_be, wr_wdata,
    input  rd_gnt, rd_data, wr_gnt
  );
  modport slave (
    input  rd_req, rd_addr, rd_be, wr_req, wr_addr, wr_be, wr_wdata,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/naive_arb_channel.sv
// One arbitrated channel: requester select, grant fan-out and favoured-master pointer.
// NAIVE_ARB_ROUND_ROBIN_EN enables the rotating pointer; otherwise m0 always wins ties.
module naive_arb_channel
  import naive_bus_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_MST-1:0] req,
  input  logic               bus_gnt,
  output arb_mst_t           sel,
  output logic               active,
  output logic [NUM_MST-1:0] gnt
);
  arb_mst_t pri;

`ifdef NAIVE_ARB_ROUND_ROBIN_EN
  // Pointer moves only on a completed handshake so a stalled selection stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   pri <= M_CORE;
    else if (active && bus_gnt) pri <= (sel == M_CORE) ? M_DBG : M_CORE;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign pri = M_CORE;
`endif

  always_comb begin
    sel = M_CORE;
    if (req == 2'b10)      sel = M_DBG;
    else if (req == 2'b11) sel = pri;
  end

  assign active = |req;
  assign gnt[0] = bus_gnt & req[0] & (sel == M_CORE);
  assign gnt[1] = bus_gnt & req[1] & (sel == M_DBG);
endmodule

// File: rtl/naive_bus_arbiter2.sv
// Two-master to one-slave naive bus arbiter; rd and wr arbitrated independently.
// Optional round-robin ties via NAIVE_ARB_ROUND_ROBIN_EN (fixed m0 priority otherwise).
module naive_bus_arbiter2
  import naive_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic      clk,
  input logic      rst,
  naive_bus.slave  m0,
  naive_bus.slave  m1,
  naive_bus.master s
);
  arb_mst_t           rd_sel, wr_sel, rd_owner;
  logic               rd_act, wr_act, rd_owner_vld;
  logic [NUM_MST-1:0] rd_gnt, wr_gnt;

  logic [ADDR_W-1:0]   rd_addr, wr_addr;
  logic [DATA_W/8-1:0] rd_be, wr_be;
  logic [DATA_W-1:0]   wdata;

  naive_arb_channel u_rd (
    .clk(clk), .rst(rst), .req({m1.rd_req, m0.rd_req}), .bus_gnt(s.rd_gnt),
    .sel(rd_sel), .active(rd_act), .gnt(rd_gnt)
  );

  naive_arb_channel u_wr (
    .clk(clk), .rst(rst), .req({m1.wr_req, m0.wr_req}), .bus_gnt(s.wr_gnt),
    .sel(wr_sel), .active(wr_act), .gnt(wr_gnt)
  );

  always_comb begin
    rd_addr = '0;
    rd_be   = '0;
    if (rd_act) begin
      rd_addr = (rd_sel == M_DBG) ? m1.rd_addr : m0.rd_addr;
      rd_be   = (rd_sel == M_DBG) ? m1.rd_be   : m0.rd_be;
    end
  end

  always_comb begin
    wr_addr = '0;
    wr_be   = '0;
    wdata   = '0;
    if (wr_act) begin
      wr_addr = (wr_sel == M_DBG) ? m1.wr_addr  : m0.wr_addr;
      wr_be   = (wr_sel == M_DBG) ? m1.wr_be    : m0.wr_be;
      wdata   = (wr_sel == M_DBG) ? m1.wr_wdata : m0.wr_wdata;
    end
  end

  assign s.rd_req   = rd_act;
  assign s.rd_addr  = rd_addr;
  assign s.rd_be    = rd_be;
  assign s.wr_req   = wr_act;
  assign s.wr_addr  = wr_addr;
  assign s.wr_be    = wr_be;
  assign s.wr_wdata = wdata;

  assign m0.rd_gnt = rd_gnt[0];
  assign m1.rd_gnt = rd_gnt[1];
  assign m0.wr_gnt = wr_gnt[0];
  assign m1.wr_gnt = wr_gnt[1];

  // Remember who won the read so next cycle's slave data goes back to them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner_vld <= 1'b0;
      rd_owner     <= M_CORE;
    end else begin
      rd_owner_vld <= s.rd_req & s.rd_gnt;
      if (s.rd_req & s.rd_gnt) rd_owner <= rd_sel;
    end
  end

  assign m0.rd_data = (rd_owner_vld && rd_owner == M_CORE) ? s.rd_data : '0;
  assign m1.rd_data = (rd_owner_vld && rd_owner == M_DBG)  ? s.rd_data : '0;
endmodule

// File: tb/tb_naive_bus_arbiter2.sv
// Directed table-driven bench for naive_bus_arbiter2, with ifdef'd expectations for the priority mode.
module tb_naive_bus_arbiter2;
  localparam logic [31:0] A0R = 32'h0000_1000, A1R = 32'h0000_2000;
  localparam logic [31:0] A0W = 32'h0000_3000, A1W = 32'h0000_4000;
  localparam logic [31:0] D0  = 32'hA0A0_0001, D1  = 32'hB1B1_0002;

  typedef struct packed {
    logic r0, r1, w0, w1, srg, swg;
    logic [31:0] sd;
  } in_t;

  typedef struct packed {
    logic g0, g1, gw0, gw1, srreq, swreq;
    logic [3:0]  sbe;
    logic [31:0] sra, swa, swd, rd0, rd1;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  naive_bus #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
  naive_bus #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
  naive_bus #(.ADDR_W(32), .DATA_W(32)) s_bus ();

  naive_bus_arbiter2 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus)
  );

  always #5 clk = ~clk;

  function automatic in_t ii(input logic r0, r1, w0, w1, srg, swg, input logic [31:0] sd);
    in_t x;
    x = '{r0: r0, r1: r1, w0: w0, w1: w1, srg: srg, swg: swg, sd: sd};
    return x;
  endfunction

  function automatic vec_t mk(input in_t x, input logic g0, g1, gw0, gw1,
                              input logic [3:0] be, input logic [31:0] sra, swa, swd, rd0, rd1);
    vec_t v;
    v.i = x;
    v.e = '{g0: g0, g1: g1, gw0: gw0, gw1: gw1, srreq: x.r0 | x.r1, swreq: x.w0 | x.w1,
            sbe: be, sra: sra, swa: swa, swd: swd, rd0: rd0, rd1: rd1};
    return v;
  endfunction

  function automatic out_t observe();
    out_t o;
    o = '{g0: m0_bus.rd_gnt, g1: m1_bus.rd_gnt, gw0: m0_bus.wr_gnt, gw1: m1_bus.wr_gnt,
          srreq: s_bus.rd_req, swreq: s_bus.wr_req, sbe: s_bus.rd_be, sra: s_bus.rd_addr,
          swa: s_bus.wr_addr, swd: s_bus.wr_wdata, rd0: m0_bus.rd_data, rd1: m1_bus.rd_data};
    return o;
  endfunction

  task automatic drive(input in_t x);
    m0_bus.rd_req = x.r0;  m1_bus.rd_req = x.r1;
    m0_bus.wr_req = x.w0;  m1_bus.wr_req = x.w1;
    s_bus.rd_gnt  = x.srg; s_bus.wr_gnt  = x.swg;
    s_bus.rd_data = x.sd;
  endtask

  task automatic chk_out(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(ii(0, 0, 0, 0, 0, 0, 32'h0));
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_m1;
    m0_bus.rd_addr = A0R; m0_bus.rd_be = 4'hF; m0_bus.wr_addr = A0W; m0_bus.wr_be = 4'hF; m0_bus.wr_wdata = D0;
    m1_bus.rd_addr = A1R; m1_bus.rd_be = 4'h3; m1_bus.wr_addr = A1W; m1_bus.wr_be = 4'hC; m1_bus.wr_wdata = D1;

    // No ties in the table, so expectations hold for either priority mode.
    tbl[0] = mk(ii(1, 0, 0, 0, 1, 0, 32'h0),          1, 0, 0, 0, 4'hF, A0R, 0, 0, 0, 0);
    tbl[1] = mk(ii(0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF),  0, 0, 0, 0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, 0);
    tbl[2] = mk(ii(0, 1, 0, 0, 1, 0, 32'h0000_1234),  0, 1, 0, 0, 4'h3, A1R, 0, 0, 0, 0);
    tbl[3] = mk(ii(0, 0, 0, 0, 0, 0, 32'hCAFE_F00D),  0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 32'hCAFE_F00D);
    tbl[4] = mk(ii(1, 0, 0, 1, 1, 1, 32'h0),          1, 0, 0, 1, 4'hF, A0R, A1W, D1, 0, 0);
    tbl[5] = mk(ii(0, 1, 0, 0, 0, 0, 32'h0000_5555),  0, 0, 0, 0, 4'h3, A1R, 0, 0, 32'h0000_5555, 0);
    tbl[6] = mk(ii(0, 0, 0, 0, 0, 0, 32'h0000_7777),  0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    tbl[7] = mk(ii(0, 0, 1, 0, 0, 0, 32'h0),          0, 0, 0, 0, 4'h0, 0, A0W, D0, 0, 0);
    tbl[8] = mk(ii(0, 0, 1, 0, 0, 1, 32'h0),          0, 0, 1, 0, 4'h0, 0, A0W, D0, 0, 0);
    tbl[9] = mk(ii(0, 1, 0, 1, 1, 1, 32'h0),          0, 1, 0, 1, 4'h3, A1R, A1W, D1, 0, 0);

    // Reset state: idle inputs, slave driving junk read data.
    drive(ii(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF));
    @(negedge clk);
    chk_out("reset_idle", observe(), '0);
    step();
    step();
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].i);
      @(negedge clk);
      chk_out($sformatf("vec%0d", k), observe(), tbl[k].e);
      step();
    end

    // Both masters writing continuously.
    do_reset();
    drive(ii(0, 0, 1, 1, 0, 1, 32'h0));
    for (int k = 0; k < 4; k++) begin
`ifdef NAIVE_ARB_ROUND_ROBIN_EN
      exp_m1 = k[0];
`else
      exp_m1 = 1'b0;
`endif
      @(negedge clk);
      chk($sformatf("wr_alt%0d_gnt", k), {30'h0, m1_bus.wr_gnt, m0_bus.wr_gnt}, {30'h0, exp_m1, ~exp_m1});
      chk($sformatf("wr_alt%0d_data", k), s_bus.wr_wdata, exp_m1 ? D1 : D0);
      step();
    end

    // Read tie with slave stalling for 3 cycles.
    do_reset();
    drive(ii(1, 1, 0, 0, 0, 0, 32'h0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_gnt", k), {30'h0, m1_bus.rd_gnt, m0_bus.rd_gnt}, 32'h0);
      chk($sformatf("stall%0d_addr", k), s_bus.rd_addr, A0R);
      step();
    end
    s_bus.rd_gnt = 1'b1;
    @(negedge clk);
    chk("stall_release_gnt", {30'h0, m1_bus.rd_gnt, m0_bus.rd_gnt}, 32'h1);
    step();
    @(negedge clk);
`ifdef NAIVE_ARB_ROUND_ROBIN_EN
    chk("stall_next_tie", {30'h0, m1_bus.rd_gnt, m0_bus.rd_gnt}, 32'h2);
`else
    chk("stall_next_tie", {30'h0, m1_bus.rd_gnt, m0_bus.rd_gnt}, 32'h1);
`endif
    step();

    // Reset pulsed right after a granted m1 read drops the returning data.
    do_reset();
    drive(ii(0, 1, 0, 0, 1, 0, 32'h0));
    @(negedge clk);
    chk("rst_m1_gnt", {31'h0, m1_bus.rd_gnt}, 32'h1);
    step();
    drive(ii(0, 0, 0, 0, 0, 0, 32'h0000_0099));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_m1_data", m1_bus.rd_data, 32'h0);
    chk("rst_m0_data", m0_bus.rd_data, 32'h0);
    step();
    rst = 1'b0;

    // Reset after an m0 win must return the read pointer to m0.
    drive(ii(1, 0, 0, 0, 1, 0, 32'h0));
    step();
    drive(ii(0, 0, 0, 0, 0, 0, 32'h0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(ii(1, 1, 0, 0, 1, 0, 32'h0));
    @(negedge clk);
    chk("rst_pri_tie", {30'h0, m1_bus.rd_gnt, m0_bus.rd_gnt}, 32'h1);
    step();

`ifndef NAIVE_ARB_ROUND_ROBIN_EN
    // Fixed priority: m0 holds the read channel, m1 starves.
    do_reset();
    drive(ii(1, 1, 0, 0, 1, 0, 32'h0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("fixed%0d_gnt", k), {30'h0, m1_bus.rd_gnt, m0_bus.rd_gnt}, 32'h1);
      step();
    end
`endif

    drive(ii(0, 0, 0, 0, 0, 0, 32'h0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
